// File: rtl/lenet_div_32s_16s_seq.sv
// lenet_div_32s_16s_seq
//   Sequential radix-2 restoring divider: 32-bit signed dividend by 16-bit
//   signed divisor giving a 16-bit signed quotient and remainder
//   (truncating division, remainder carries the dividend's sign).
//   One operation takes 34 enabled clock edges: capture, 32 quotient-bit
//   steps, and a sign-fixup edge that raises done.
//
// Build option:
//   LENET_DIV_SAT_EN  defined   -> on ovf, dout saturates to 0x7FFF / 0x8000
//                     undefined -> on ovf, dout is the low 16 bits of the true
//                                  quotient; divide-by-zero gives 0xFFFF
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   ce     clock enable; low freezes all state and outputs
//   start  request, accepted only while ready=1 and ce=1
//   din0   signed dividend (captured with start)
//   din1   signed divisor  (captured with start)
//   ready  high while idle
//   done   one ce-cycle pulse, results valid
//   dout   signed quotient
//   rem    signed remainder
//   ovf    quotient out of 16-bit signed range, or divide-by-zero
//   dz     divisor was zero
module lenet_div_32s_16s_seq #(
    parameter int DIVIDEND_W = 32,
    parameter int DIVISOR_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] din0,
    input  logic [DIVISOR_W-1:0]  din1,
    output logic                  ready,
    output logic                  done,
    output logic [DIVISOR_W-1:0]  dout,
    output logic [DIVISOR_W-1:0]  rem,
    output logic                  ovf,
    output logic                  dz
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t      r_state;
    logic [31:0] r_dvd;      // |dividend|, kept intact for the whole operation
    logic [15:0] r_dvs;      // |divisor|, 32768 representable as unsigned
    logic [31:0] r_quo;      // partial quotient magnitude
    logic [15:0] r_prem;     // partial remainder magnitude
    logic [4:0]  r_cnt;
    logic        r_qsign;
    logic        r_rsign;

    logic [31:0] w_dvd_abs;
    logic [15:0] w_dvs_abs;
    logic [16:0] w_shift;
    logic        w_ge;
    logic [15:0] w_diff;
    logic        w_dz;
    logic        w_ovf;
    logic [15:0] w_q16;
    logic [15:0] w_rmag;
    logic [15:0] w_r16;
    logic [15:0] w_dout;

    always_comb begin
        w_dvd_abs = din0[31] ? (~din0 + 32'd1) : din0;
        w_dvs_abs = din1[15] ? (~din1 + 16'd1) : din1;

        // Dividend bits enter MSB first; bit index 31-cnt equals ~cnt.
        w_shift = {r_prem, r_dvd[~r_cnt]};
        w_ge    = (w_shift >= {1'b0, r_dvs});
        // Only the low 16 bits of the difference are kept: after a successful
        // subtract the remainder is below the divisor, so bit 16 is zero.
        w_diff  = w_shift[15:0] - r_dvs;

        w_dz    = (r_dvs == '0);
        w_ovf   = w_dz | (r_qsign ? (r_quo > 32'd32768) : (r_quo > 32'd32767));
        w_q16   = r_qsign ? (~r_quo[15:0] + 16'd1) : r_quo[15:0];
        // With a zero divisor the remainder reports the dividend's low half,
        // recovered by re-applying its sign to the stored magnitude.
        w_rmag  = w_dz ? r_dvd[15:0] : r_prem;
        w_r16   = r_rsign ? (~w_rmag + 16'd1) : w_rmag;
`ifdef LENET_DIV_SAT_EN
        // For divide-by-zero the quotient sign equals the dividend sign,
        // so the same saturation rule covers it.
        w_dout  = w_ovf ? (r_qsign ? 16'h8000 : 16'h7FFF) : w_q16;
`else
        w_dout  = w_dz ? 16'hFFFF : w_q16;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_quo   <= '0;
            r_prem  <= '0;
            r_cnt   <= '0;
            r_qsign <= 1'b0;
            r_rsign <= 1'b0;
            ready   <= 1'b1;
            done    <= 1'b0;
            dout    <= '0;
            rem     <= '0;
            ovf     <= 1'b0;
            dz      <= 1'b0;
        end else if (ce) begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dvd   <= w_dvd_abs;
                        r_dvs   <= w_dvs_abs;
                        r_qsign <= din0[31] ^ din1[15];
                        r_rsign <= din0[31];
                        r_quo   <= '0;
                        r_prem  <= '0;
                        r_cnt   <= '0;
                        ready   <= 1'b0;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_prem <= w_ge ? w_diff : w_shift[15:0];
                    r_quo  <= {r_quo[30:0], w_ge};
                    r_cnt  <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    dout    <= w_dout;
                    rem     <= w_r16;
                    ovf     <= w_ovf;
                    dz      <= w_dz;
                    done    <= 1'b1;
                    ready   <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
